// File: rtl/fir2_pkg.sv
// fir2_pkg: widths, default taps and output rounding shared by the fir2_parallel slice.
// Macro FIR_SAT_EN: when defined, outputs saturate; otherwise they wrap to the low 16 bits.
package fir2_pkg;

   localparam int TAPS = 8;
   localparam int DW   = 16;
   localparam int CW   = 16;
   localparam int ACCW = 38;
   localparam int PH   = TAPS / 2;

   // h[0] sits in the least significant 16 bits
   localparam logic [TAPS*CW-1:0] DEF_COEFS = {
      16'h0800, 16'h1000, 16'h1800, 16'h2000,
      16'h2000, 16'h1800, 16'h1000, 16'h0800
   };

   localparam logic signed [ACCW-1:0] RND     = 38'sd16384;
   localparam logic signed [ACCW-1:0] OUT_MAX = 38'sd32767;
   localparam logic signed [ACCW-1:0] OUT_MIN = -38'sd32768;

   // Q1.15 round-half-up, then saturate or wrap to DW bits
   function automatic logic signed [DW-1:0] round_out(input logic signed [ACCW-1:0] acc);
      logic signed [ACCW-1:0] r;
      r = (acc + RND) >>> (CW - 1);
`ifdef FIR_SAT_EN
      if (r > OUT_MAX) begin
         r = OUT_MAX;
      end else if (r < OUT_MIN) begin
         r = OUT_MIN;
      end
      return DW'(r);
`else
      return DW'(r);
`endif
   endfunction

   function automatic logic [PH*CW-1:0] phase_coefs(input logic [TAPS*CW-1:0] c, input int ph);
      logic [PH*CW-1:0] r;
      r = '0;
      for (int j = 0; j < PH; j++) begin
         r[j*CW +: CW] = c[(2*j+ph)*CW +: CW];
      end
      return r;
   endfunction

   // Hs taps are h[2j] + h[2j+1], widened by one bit so the sum cannot overflow
   function automatic logic [PH*(CW+1)-1:0] sum_coefs(input logic [TAPS*CW-1:0] c);
      logic [PH*(CW+1)-1:0] r;
      logic [CW:0] a;
      logic [CW:0] b;
      r = '0;
      for (int j = 0; j < PH; j++) begin
         a = {c[(2*j+1)*CW-1], c[2*j*CW +: CW]};
         b = {c[(2*j+2)*CW-1], c[(2*j+1)*CW +: CW]};
         r[j*(CW+1) +: (CW+1)] = a + b;
      end
      return r;
   endfunction

endpackage

// File: rtl/fir2_parallel_if.sv
// fir2_parallel_if: sample-pair input and filtered-pair output of the two-parallel FIR.
interface fir2_parallel_if;
   import fir2_pkg::*;

   logic signed [DW-1:0] x2k;
   logic signed [DW-1:0] x2k_1;
   logic signed [DW-1:0] y2k;
   logic signed [DW-1:0] y2k_1;

   modport master (output x2k, output x2k_1, input y2k, input y2k_1);
   modport slave  (input x2k, input x2k_1, output y2k, output y2k_1);
endinterface

// File: rtl/fir2_subfilter.sv
// fir2_subfilter: 4-tap direct-form dot product over a pair-rate delay line.
// Tap 0 is the current input; the sum is registered and sign-extended to ACCW.
module fir2_subfilter
   import fir2_pkg::*;
#(
   parameter int W = DW,
   parameter int CWS = CW,
   parameter logic [PH*CWS-1:0] COEF = '0
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic signed [W-1:0]    i_x,
   output logic signed [ACCW-1:0] o_y
);

   logic signed [W-1:0]    r_dly [PH-1];
   logic signed [W-1:0]    w_tap [PH];
   logic signed [ACCW-1:0] w_prod [PH];
   logic signed [ACCW-1:0] w_sum;
   logic signed [ACCW-1:0] r_y;

   assign w_tap[0] = i_x;

   generate
      for (genvar gi = 1; gi < PH; gi++) begin : g_tap
         assign w_tap[gi] = r_dly[gi-1];
      end
      for (genvar gi = 0; gi < PH; gi++) begin : g_mul
         localparam logic signed [CWS-1:0] C = COEF[gi*CWS +: CWS];
         logic signed [ACCW-1:0] w_xe;
         logic signed [ACCW-1:0] w_ce;
         assign w_xe = ACCW'(w_tap[gi]);
         assign w_ce = ACCW'(C);
         assign w_prod[gi] = w_xe * w_ce;
      end
   endgenerate

   always_comb begin
      w_sum = '0;
      for (int i = 0; i < PH; i++) begin
         w_sum = w_sum + w_prod[i];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < PH-1; i++) begin
            r_dly[i] <= '0;
         end
         r_y <= '0;
      end else begin
         r_dly[0] <= i_x;
         for (int i = 1; i < PH-1; i++) begin
            r_dly[i] <= r_dly[i-1];
         end
         r_y <= w_sum;
      end
   end

   assign o_y = r_y;

endmodule

// File: rtl/fir2_parallel.sv
// fir2_parallel: two-parallel 8-tap FIR built from three 4-tap fast-FIR sub-filters.
// Two-cycle latency from input capture; macro FIR_SAT_EN selects saturating output.
module fir2_parallel
   import fir2_pkg::*;
#(
   parameter logic [TAPS*CW-1:0] COEFS = DEF_COEFS
) (
   input logic            clk,
   input logic            rst_n,
   fir2_parallel_if.slave bus
);

   localparam logic [PH*CW-1:0]     H0_C = phase_coefs(COEFS, 0);
   localparam logic [PH*CW-1:0]     H1_C = phase_coefs(COEFS, 1);
   localparam logic [PH*(CW+1)-1:0] HS_C = sum_coefs(COEFS);

   logic signed [DW-1:0]   r_x0;
   logic signed [DW-1:0]   r_x1;
   logic signed [DW:0]     w_s;
   logic signed [ACCW-1:0] w_a;
   logic signed [ACCW-1:0] w_b;
   logic signed [ACCW-1:0] w_c;
   logic signed [ACCW-1:0] r_b_prev;
   logic signed [ACCW-1:0] w_y0_acc;
   logic signed [ACCW-1:0] w_y1_acc;
   logic signed [DW-1:0]   r_y0;
   logic signed [DW-1:0]   r_y1;

   assign w_s = {r_x0[DW-1], r_x0} + {r_x1[DW-1], r_x1};

   fir2_subfilter #(.W(DW), .CWS(CW), .COEF(H0_C)) u_h0 (
      .clk(clk), .rst(rst_n), .i_x(r_x0), .o_y(w_a)
   );
   fir2_subfilter #(.W(DW), .CWS(CW), .COEF(H1_C)) u_h1 (
      .clk(clk), .rst(rst_n), .i_x(r_x1), .o_y(w_b)
   );
   fir2_subfilter #(.W(DW+1), .CWS(CW+1), .COEF(HS_C)) u_hs (
      .clk(clk), .rst(rst_n), .i_x(w_s), .o_y(w_c)
   );

   // Even output needs B from the previous pair; odd output is the Karatsuba-style difference
   assign w_y0_acc = w_a + r_b_prev;
   assign w_y1_acc = w_c - w_a - w_b;

   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         r_x0     <= '0;
         r_x1     <= '0;
         r_b_prev <= '0;
         r_y0     <= '0;
         r_y1     <= '0;
      end else begin
         r_x0     <= bus.x2k;
         r_x1     <= bus.x2k_1;
         r_b_prev <= w_b;
         r_y0     <= round_out(w_y0_acc);
         r_y1     <= round_out(w_y1_acc);
      end
   end

   assign bus.y2k   = r_y0;
   assign bus.y2k_1 = r_y1;

endmodule

// File: tb/tb_fir2_parallel.sv
// tb_fir2_parallel: stimulus queues the expected output pair for every input pair;
// a monitor pops and compares once that pair's result reaches y2k/y2k_1.
module tb_fir2_parallel;

   logic clk = 1'b0;
   logic rst_n = 1'b1;

   fir2_parallel_if bus ();

   fir2_parallel dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic signed [15:0] e0;
      logic signed [15:0] e1;
      int                 due;
      string              tag;
   } exp_t;

   exp_t sbq[$];
   int cyc = 0;
   int n_vec = 0;
   int n_bad = 0;
   logic signed [15:0] hist [8];
   int hc [8] = '{2048, 4096, 6144, 8192, 8192, 6144, 4096, 2048};

`ifdef FIR_SAT_EN
   localparam logic signed [15:0] POS_SS = 16'sh7FFF;
   localparam logic signed [15:0] NEG_SS = 16'sh8000;
`else
   localparam logic signed [15:0] POS_SS = 16'sh9FFF;
   localparam logic signed [15:0] NEG_SS = 16'sh6000;
`endif

   always @(posedge clk) cyc++;

   function automatic logic signed [15:0] rnd16();
      logic [31:0] r;
      r = $urandom();
      return r[15:0];
   endfunction

   // Direct-form golden model, one sample at a time
   task automatic model_step(input logic signed [15:0] x, output logic signed [15:0] y);
      longint acc;
      longint r;
      for (int i = 7; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = x;
      acc = 0;
      for (int i = 0; i < 8; i++) acc += longint'(hist[i]) * longint'(hc[i]);
      r = (acc + 64'sd16384) >>> 15;
`ifdef FIR_SAT_EN
      if (r > 32767) r = 32767;
      else if (r < -32768) r = -32768;
`endif
      y = r[15:0];
   endtask

   task automatic apply(input logic signed [15:0] a, input logic signed [15:0] b,
                        input bit hand, input logic signed [15:0] h0,
                        input logic signed [15:0] h1, input string tag);
      logic signed [15:0] m0;
      logic signed [15:0] m1;
      bus.x2k = a;
      bus.x2k_1 = b;
      m0 = '0;
      m1 = '0;
      if (!rst_n) begin
         model_step(a, m0);
         model_step(b, m1);
         if (hand) begin
            m0 = h0;
            m1 = h1;
         end
      end
      sbq.push_back('{e0: m0, e1: m1, due: cyc + 3, tag: tag});
   endtask

   task automatic pair_m(input logic signed [15:0] a, input logic signed [15:0] b, input string tag);
      @(negedge clk);
      apply(a, b, 1'b0, '0, '0, tag);
   endtask

   task automatic pair_h(input logic signed [15:0] a, input logic signed [15:0] b,
                         input logic signed [15:0] h0, input logic signed [15:0] h1, input string tag);
      @(negedge clk);
      apply(a, b, 1'b1, h0, h1, tag);
   endtask

   // Assert reset for n cycles with random inputs; everything in flight must read 0
   task automatic reset_for(input int n);
      @(negedge clk);
      rst_n = 1'b1;
      foreach (sbq[i]) begin
         sbq[i].e0 = '0;
         sbq[i].e1 = '0;
         sbq[i].tag = "flush";
      end
      foreach (hist[i]) hist[i] = '0;
      apply(rnd16(), rnd16(), 1'b0, '0, '0, "reset");
      for (int i = 1; i < n; i++) begin
         @(negedge clk);
         apply(rnd16(), rnd16(), 1'b0, '0, '0, "reset");
      end
      @(negedge clk);
      rst_n = 1'b0;
      apply(16'sd0, 16'sd0, 1'b0, '0, '0, "release");
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         #1;
         while (sbq.size() > 0 && sbq[0].due <= cyc) begin
            e = sbq.pop_front();
            n_vec++;
            if (bus.y2k !== e.e0 || bus.y2k_1 !== e.e1) begin
               n_bad++;
               $display("FAIL %s cyc=%0d: got y2k=%0d y2k_1=%0d, expected %0d/%0d",
                        e.tag, cyc, bus.y2k, bus.y2k_1, e.e0, e.e1);
            end else begin
               $display("chk %s cyc=%0d: y2k=%0d y2k_1=%0d ok", e.tag, cyc, bus.y2k, bus.y2k_1);
            end
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: time limit reached with %0d results pending, expected 0", sbq.size());
      $fatal(1, "watchdog");
   end

   initial begin : stimulus
      bus.x2k = '0;
      bus.x2k_1 = '0;
      reset_for(4);

      pair_h(16'sh4000, 16'sd0, 16'sh0400, 16'sh0800, "impulse");
      pair_h(16'sd0, 16'sd0, 16'sh0C00, 16'sh1000, "impulse");
      pair_h(16'sd0, 16'sd0, 16'sh1000, 16'sh0C00, "impulse");
      pair_h(16'sd0, 16'sd0, 16'sh0800, 16'sh0400, "impulse");
      pair_h(16'sd0, 16'sd0, 16'sh0000, 16'sh0000, "impulse");
      reset_for(2);

      pair_h(16'sd0, 16'sh4000, 16'sh0000, 16'sh0400, "odd_imp");
      pair_h(16'sd0, 16'sd0, 16'sh0800, 16'sh0C00, "odd_imp");
      pair_h(16'sd0, 16'sd0, 16'sh1000, 16'sh1000, "odd_imp");
      pair_h(16'sd0, 16'sd0, 16'sh0C00, 16'sh0800, "odd_imp");
      pair_h(16'sd0, 16'sd0, 16'sh0400, 16'sh0000, "odd_imp");
      pair_h(16'sd0, 16'sd0, 16'sh0000, 16'sh0000, "odd_imp");
      reset_for(2);

      pair_h(16'sd16384, 16'sd16384, 16'sd1024, 16'sd3072, "dc");
      pair_h(16'sd16384, 16'sd16384, 16'sd6144, 16'sd10240, "dc");
      pair_h(16'sd16384, 16'sd16384, 16'sd14336, 16'sd17408, "dc");
      pair_h(16'sd16384, 16'sd16384, 16'sd19456, 16'sd20480, "dc");
      pair_h(16'sd16384, 16'sd16384, 16'sd20480, 16'sd20480, "dc");
      pair_h(16'sd16384, 16'sd16384, 16'sd20480, 16'sd20480, "dc");
      reset_for(2);

      for (int i = 0; i < 4; i++) pair_m(16'sh7FFF, 16'sh7FFF, "pos_ramp");
      for (int i = 0; i < 3; i++) pair_h(16'sh7FFF, 16'sh7FFF, POS_SS, POS_SS, "pos_full");
      reset_for(2);

      for (int i = 0; i < 4; i++) pair_m(16'sh8000, 16'sh8000, "neg_ramp");
      for (int i = 0; i < 3; i++) pair_h(16'sh8000, 16'sh8000, NEG_SS, NEG_SS, "neg_full");
      reset_for(2);

      for (int i = 0; i < 500; i++) pair_m(rnd16(), rnd16(), "random");
      reset_for(3);
      for (int i = 0; i < 500; i++) pair_m(rnd16(), rnd16(), "random");

      for (int i = 0; i < 10 && sbq.size() > 0; i++) @(negedge clk);
      #2;
      if (sbq.size() != 0) begin
         n_vec++;
         n_bad++;
         $display("FAIL drain: %0d results still pending, expected 0", sbq.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/fir2_parallel.md
# fir2_parallel

Two-parallel 8-tap FIR filter that accepts two signed 16-bit samples per clock and produces two filtered samples per clock. It uses the fast FIR algorithm (FFA) with three 4-tap sub-filters instead of two full 8-tap filters. The block is free-running with no handshake, and sits in the datapath between a sample source and a downstream consumer.

## Interface
Parameters:
- `COEFS`, default from `fir2_pkg::DEF_COEFS`: 8×16-bit signed Q1.15 taps packed with h[0] in the LSBs. Defaults are h[0..7] = 0x0800, 0x1000, 0x1800, 0x2000, 0x2000, 0x1800, 0x1000, 0x0800.

Ports:
- `clk`, input, 1 bit: single clock; rising edge active.
- `rst_n`, input, 1 bit: reset. Reset is asynchronous and active-high, so `rst_n`=1 resets the block despite the name.
- `x2k`, input, 16 bits signed: sample x(2k), the older sample of the pair.
- `x2k_1`, input, 16 bits signed: sample x(2k+1), the newer sample of the pair.
- `y2k`, output, 16 bits signed: y(2k).
- `y2k_1`, output, 16 bits signed: y(2k+1).

## Operation
- Filter definition: y(n) = Σ h[i]·x(n−i) for i = 0..7, Q1.15 arithmetic. The outputs must be bit-exact with the direct-form result, with all internal math at full precision.
- Polyphase split:
  - H0 = {h0, h2, h4, h6}
  - H1 = {h1, h3, h5, h7}
  - Hs = H0 + H1, with 17-bit coefficients precomputed from the parameter.
- Per cycle, with x0 = `x2k`, x1 = `x2k_1` and s = x0 + x1 (17 bits):
  - A = H0·x0
  - B = H1·x1
  - C = Hs·s
  - Each sub-filter keeps a 3-deep pair-rate delay line of its own input.
- Output equations:
  - y(2k) = A + z⁻¹B, where z⁻¹B is the B value from the previous cycle.
  - y(2k+1) = C − A − B.
- Widths: products 33 bits; sums carried in a 38-bit accumulator.
- Output formatting:
  - Round by adding 2^14, then arithmetic right shift by 15.
  - With `FIR_SAT_EN`, saturate to [−32768, 32767]; otherwise keep the low 16 bits.
- Reset:
  - Clears all delay lines, the z⁻¹B register, input/output registers and both outputs to 0.
  - Reset asserted mid-stream discards all history. After release, the filter behaves as if every earlier sample were 0.
- There is no valid/ready handshake. A new pair is consumed every cycle while not in reset.

## Timing
- Inputs are registered at rising edge n.
- Outputs are registered. The pair captured at edge n appears on `y2k`/`y2k_1` after edge n+2, giving a fixed latency of 2 cycles.
- Throughput is 2 samples per cycle, sustained.
- Both outputs update on the same edge.
- Outputs read 0 during reset and for 2 cycles after release, until the first registered result arrives.

## Configuration
- `FIR_SAT_EN` defined: rounded results outside the 16-bit range clamp to 32767 or −32768.
- `FIR_SAT_EN` undefined: two's-complement wrap of the rounded result, i.e. the low 16 bits.

## Structure
- Package `fir2_pkg` holds:
  - TAPS = 8, DW = 16, CW = 16, ACCW = 38
  - `DEF_COEFS`
  - the round/saturate function
- Sub-module `fir2_subfilter`: a 4-tap direct-form dot product with a parameterised input/coefficient width. It is instantiated three times, as H0, H1 and Hs (Hs uses 17-bit input and coefficients).

## Test plan
- Reset: hold `rst_n`=1 with random inputs → `y2k` = `y2k_1` = 0. Release → outputs stay 0 until the first captured pair emerges 2 edges later.
- Impulse: pair (0x4000, 0) followed by zeros → output sequence y(0..7) = 0x0400, 0x0800, 0x0C00, 0x1000, 0x1000, 0x0C00, 0x0800, 0x0400 across 4 cycles (`y2k` first in each pair), then 0.
- Odd impulse: pair (0, 0x4000) → `y2k_1` = 0x0400 in the first output cycle, with the sequence shifted by one sample.
- DC: constant 16384 on both inputs → steady-state outputs 20480/20480.
- Saturation: constant 32767 → 32767 with `FIR_SAT_EN` defined; 0x9FFF (−24577) without it. Constant −32768 → −32768 with `FIR_SAT_EN`.
- Random stream: 1000 random pairs plus a mid-stream reset → every output matches a direct-form golden model that is also reset, with 0 mismatches.
